mx_fpga_id_flash_loader: RTL and testbench
==========================================

Name: mx_fpga_id_flash_loader

Overview:
Serves the FPGA identification/options table on the slave side of fpga_id_if. It is the block directly downstream of the FPGA ID CSR bridge, which drives the read address and consumes the read data.
After reset, it fetches WORDS_CNT 32-bit words from an external SPI configuration flash into local storage and validates a magic word in word 0.
It then answers rd_addr with 1-cycle registered rd_data. Status outputs are intended for a status register.

Parameters:
WORDS_CNT, 16, number of 32-bit words loaded and served; legal range 1..256.
FLASH_BASE, 24'h000000, flash byte address of word 0.
SCK_DIV, 4, SPI SCK half-period in clk_i cycles; must be >= 1.
MAGIC, 32'h4D58_4944, required value of word 0 ("MXID").

Ports:
clk_i  in  1  system clock; all logic is on the rising edge.
rst_i  in  1  synchronous, active-high reset.
rd_addr_i  in  8  fpga_id_if rd_addr: word index.
rd_data_o  out  32  fpga_id_if rd_data: word at rd_addr_i.
reload_i  in  1  single-cycle pulse that restarts the flash load.
load_done_o  out  1  table is loaded and the magic word matched.
load_err_o  out  1  load finished but word 0 != MAGIC.
spi_cs_n_o  out  1  flash chip select, active low.
spi_sck_o  out  1  SPI clock (mode 0).
spi_mosi_o  out  1  SPI data to flash.
spi_miso_i  in  1  SPI data from flash.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0, rd_data_o=0, load_done_o=0, load_err_o=0. FSM enters IDLE.
- Reset mid-load: the load is aborted immediately and CS goes high on the reset edge. A fresh load starts after reset release.
- FSM states: IDLE -> CMD -> DATA -> GAP -> CHECK -> DONE or ERR.
  - IDLE: the first cycle with rst_i=0 goes to CMD and drives spi_cs_n_o low.
  - CMD: shifts 32 bits MSB-first: 8'h03 followed by FLASH_BASE[23:0].
  - DATA: shifts in WORDS_CNT*32 bits. spi_mosi_o=0 throughout.
  - GAP: spi_cs_n_o high and spi_sck_o low for SCK_DIV cycles.
  - CHECK: one cycle; compares stored word 0 with MAGIC and goes to DONE (load_done_o=1) or ERR (load_err_o=1).
- SPI mode 0:
  - SCK idles low; each bit is SCK_DIV cycles low then SCK_DIV cycles high.
  - MOSI is updated while SCK is low, at the start of the bit.
  - MISO is sampled on the clk_i cycle where spi_sck_o rises.
  - Bit counter width is ceil(log2(32*(WORDS_CNT+1))) or more.
- Word assembly: bytes arrive MSB-first within each byte. Within a word, bytes are little-endian: the first byte maps to [7:0] and the fourth byte to [31:24]. The word is written to storage on its 32nd sampled bit; index increments by 1.
- Storage: WORDS_CNT x 32 array, single write port, single read port.
- Read port:
  - rd_data_o is registered with 1-cycle latency: the value presented at edge N+1 reflects rd_addr_i at edge N.
  - rd_data_o=0 when rd_addr_i >= WORDS_CNT, when not in DONE, or when in ERR.
  - Reads never stall the load.
- reload_i:
  - Accepted only in DONE or ERR: clears load_done_o and load_err_o next cycle and enters CMD.
  - Ignored in IDLE, CMD, DATA, GAP and CHECK.
  - reload_i coincident with rst_i: reset wins.
- load_done_o and load_err_o are mutually exclusive, and never both 1.
- Load duration from reset release to load_done_o: (32+32*WORDS_CNT)*2*SCK_DIV + SCK_DIV + 3 cycles, +/-1 cycle. The verification model uses this window.

Test Plan:
- Nominal load: flash model holds MAGIC at word 0 and 32'h0000_00A5 at word 1; WORDS_CNT=16, SCK_DIV=4 -> MOSI shows 8'h03 and 24'h000000; load_done_o=1 within the stated window; rd_addr_i=1 gives rd_data_o=32'h0000_00A5 one cycle later.
- Byte order: flash bytes 44 49 58 4D for word 0 -> read of address 0 returns 32'h4D58_4944 and load_done_o=1.
- Bad magic: word 0 = 32'hFFFF_FFFF -> load_err_o=1, load_done_o=0, rd_data_o=0 for addresses 0..255.
- Out-of-range address: rd_addr_i=16 with WORDS_CNT=16 after DONE -> rd_data_o=0. Before DONE, address 0 -> 0.
- Reset mid-DATA: assert rst_i at bit 100 -> next cycle CS high, SCK low, outputs 0; after release a full reload completes with correct data.
- Reload: after DONE, change flash word 2 to 32'h1234_5678 and pulse reload_i -> load_done_o drops next cycle and later returns 1; address 2 reads 32'h1234_5678. A reload_i pulse during DATA has no effect.

Source files
------------

// File: rtl/mx_fpga_id_flash_loader.sv
// FPGA ID / options table loader.
// After reset (or an accepted reload) the block reads WORDS_CNT 32-bit words
// from an SPI configuration flash (read command 0x03, mode 0) into a local
// table, checks word 0 against MAGIC and then serves the table on the
// fpga_id_if read port.
//
// Read port handshake: there is no valid/ready pair. rd_addr_i is sampled
// on every rising clk_i edge and rd_data_o presents the addressed word from
// that same edge onwards (one cycle of latency). rd_data_o is zero unless
// the table is loaded and valid (DONE) and the address is inside the table.
// Reads never stall the loader.
module mx_fpga_id_flash_loader #(
  parameter int          WORDS_CNT  = 16,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          SCK_DIV    = 4,
  parameter logic [31:0] MAGIC      = 32'h4D58_4944
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  input  logic        reload_i,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic        spi_cs_n_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  // Command bits plus data bits shifted during one chip-select session.
  localparam int TOTAL_BITS = 32 * (WORDS_CNT + 1);
  localparam int BW         = $clog2(TOTAL_BITS) + 1;
  localparam int DW         = $clog2(2 * SCK_DIV + 1);
  localparam int AW         = (WORDS_CNT > 1) ? $clog2(WORDS_CNT) : 1;

  localparam logic [BW-1:0] LAST_BIT     = BW'(TOTAL_BITS - 1);
  localparam logic [BW-1:0] LAST_CMD_BIT = BW'(31);
  localparam logic [DW-1:0] RISE_CNT     = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] FALL_CNT     = DW'(2 * SCK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST     = DW'(SCK_DIV - 1);
  localparam logic [31:0]   READ_CMD     = {8'h03, FLASH_BASE};
  localparam logic [31:0]   CMD_AFTER_MSB = READ_CMD << 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_DATA  = 3'd2,
    S_GAP   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Loader state; kept as a plain named register so checkers can bind to it.
  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [BW-1:0]   bit_q;
  logic [31:0]     cmd_sr_q;
  logic [6:0]      byte_sr_q;
  logic [23:0]     word_sr_q;
  logic [AW-1:0]   widx_q;
  logic            sck_q;
  logic            cs_n_q;
  logic            mosi_q;
  logic            done_q;
  logic            err_q;
  logic [31:0]     rd_data_q;
  logic [31:0]     mem_q [WORDS_CNT];

  logic            sck_rise_d;
  logic            bit_end_d;
  logic [7:0]      new_byte_d;
  logic            we_d;
  logic [31:0]     wdata_d;
  logic            in_range_d;
  logic            start_d;

  // Bit timing strobes, byte/word assembly and table write enable.
  always_comb begin
    sck_rise_d = (div_q == RISE_CNT);
    bit_end_d  = (div_q == FALL_CNT);
    new_byte_d = {byte_sr_q, spi_miso_i};
    // Bytes of a word arrive little-endian: the fourth byte lands in [31:24].
    wdata_d    = {new_byte_d, word_sr_q};
    we_d       = (state_q == S_DATA) && sck_rise_d && (bit_q[4:0] == 5'd31);
    in_range_d = ({1'b0, rd_addr_i} < 9'(WORDS_CNT));
    start_d    = (state_q == S_IDLE) ||
                 (((state_q == S_DONE) || (state_q == S_ERR)) && reload_i);
  end

  // Loader FSM: SPI sequencing, data capture and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      cmd_sr_q  <= '0;
      byte_sr_q <= '0;
      word_sr_q <= '0;
      widx_q    <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_d) begin
            // Open a fresh session; the first command bit is set up
            // immediately so it is stable for the first rising SCK.
            state_q  <= S_CMD;
            div_q    <= '0;
            bit_q    <= '0;
            widx_q   <= '0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b0;
            mosi_q   <= READ_CMD[31];
            cmd_sr_q <= CMD_AFTER_MSB;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end

        S_CMD, S_DATA: begin
          if (bit_end_d) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= bit_q + BW'(1);
            if (state_q == S_CMD) begin
              mosi_q   <= cmd_sr_q[31];
              cmd_sr_q <= cmd_sr_q << 1;
              if (bit_q == LAST_CMD_BIT) begin
                state_q <= S_DATA;
                mosi_q  <= 1'b0;
              end
            end else begin
              mosi_q <= 1'b0;
              if (bit_q == LAST_BIT) begin
                state_q <= S_GAP;
                cs_n_q  <= 1'b1;
              end
            end
          end else begin
            div_q <= div_q + DW'(1);
            if (sck_rise_d) begin
              sck_q <= 1'b1;
              // MISO is captured on the clock where SCK rises.
              if (state_q == S_DATA) begin
                byte_sr_q <= new_byte_d[6:0];
                if (bit_q[2:0] == 3'd7) begin
                  word_sr_q <= {new_byte_d, word_sr_q[23:8]};
                end
                if (bit_q[4:0] == 5'd31) begin
                  widx_q <= widx_q + AW'(1);
                end
              end
            end
          end
        end

        S_GAP: begin
          sck_q  <= 1'b0;
          cs_n_q <= 1'b1;
          if (div_q == GAP_LAST) begin
            div_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end

        S_CHECK: begin
          if (mem_q[0] == MAGIC) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Table storage: one write per completed 32-bit word.
  always_ff @(posedge clk_i) begin
    if (we_d) begin
      mem_q[widx_q] <= wdata_d;
    end
  end

  // Registered read port: zero unless loaded, valid and in range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if ((state_q == S_DONE) && in_range_d) begin
      rd_data_q <= mem_q[rd_addr_i[AW-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign spi_cs_n_o  = cs_n_q;
  assign spi_sck_o   = sck_q;
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_mx_fpga_id_flash_loader.sv
// Bench for mx_fpga_id_flash_loader: behavioural SPI flash, byte-array
// reference table, and a read scoreboard fed by the stimulus driver.
module tb_mx_fpga_id_flash_loader;

  localparam int          W        = 16;
  localparam int          D        = 4;
  localparam logic [23:0] FL_BASE  = 24'h000000;
  localparam logic [31:0] MAGIC    = 32'h4D58_4944;
  localparam int          LOAD_CYC = (32 + 32 * W) * 2 * D + D + 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rd_addr_i = '0;
  logic [31:0] rd_data_o;
  logic        reload_i = 1'b0;
  logic        load_done_o;
  logic        load_err_o;
  logic        spi_cs_n_o;
  logic        spi_sck_o;
  logic        spi_mosi_o;
  logic        spi_miso_i = 1'b0;

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  mx_fpga_id_flash_loader #(
    .WORDS_CNT (W),
    .FLASH_BASE(FL_BASE),
    .SCK_DIV   (D),
    .MAGIC     (MAGIC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .reload_i   (reload_i),
    .load_done_o(load_done_o),
    .load_err_o (load_err_o),
    .spi_cs_n_o (spi_cs_n_o),
    .spi_sck_o  (spi_sck_o),
    .spi_mosi_o (spi_mosi_o),
    .spi_miso_i (spi_miso_i)
  );

  // ---------------- counters and checks ----------------
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input int act, input int exp);
    vecs++;
    if (act < exp - 1 || act > exp + 1) begin
      errs++;
      $display("FAIL %s: got %0d cycles expected %0d +/-1", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] flash_b [0:1023];
  bit         model_done = 1'b0;

  function automatic void set_word(input int k, input logic [31:0] v);
    int a;
    a = int'(FL_BASE) + 4 * k;
    flash_b[a % 1024]       = v[7:0];
    flash_b[(a + 1) % 1024] = v[15:8];
    flash_b[(a + 2) % 1024] = v[23:16];
    flash_b[(a + 3) % 1024] = v[31:24];
  endfunction

  function automatic logic [31:0] model_word(input int k);
    int a;
    a = int'(FL_BASE) + 4 * k;
    return {flash_b[(a + 3) % 1024], flash_b[(a + 2) % 1024],
            flash_b[(a + 1) % 1024], flash_b[a % 1024]};
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    if (!model_done || a >= W) return 32'h0;
    return model_word(a);
  endfunction

  function automatic void fill_random(input bit good_magic);
    for (int k = 0; k < W; k++) set_word(k, $urandom);
    if (good_magic) begin
      flash_b[int'(FL_BASE) % 1024]       = 8'h44;
      flash_b[(int'(FL_BASE) + 1) % 1024] = 8'h49;
      flash_b[(int'(FL_BASE) + 2) % 1024] = 8'h58;
      flash_b[(int'(FL_BASE) + 3) % 1024] = 8'h4D;
    end
  endfunction

  // ---------------- behavioural SPI flash (mode 0) ----------------
  int          fl_bits = 0;
  logic [31:0] fl_cmd  = '0;

  always @(negedge spi_cs_n_o) begin
    fl_bits = 0;
    fl_cmd  = '0;
  end

  always @(posedge spi_cs_n_o) fl_bits = 0;

  always @(posedge spi_sck_o) begin
    if (spi_cs_n_o == 1'b0) begin
      if (fl_bits < 32) begin
        fl_cmd = {fl_cmd[30:0], spi_mosi_o};
      end else if (spi_mosi_o !== 1'b0) begin
        errs++;
        $display("FAIL mosi_data: got %b expected 0 at bit %0d", spi_mosi_o, fl_bits);
      end
      fl_bits++;
      if (fl_bits == 32) chk("spi_cmd", fl_cmd, {8'h03, FL_BASE});
    end
  end

  always @(negedge spi_sck_o) begin
    int d;
    logic [7:0] b;
    if (spi_cs_n_o == 1'b0 && fl_bits >= 32) begin
      d = fl_bits - 32;
      b = flash_b[(int'(FL_BASE) + d / 8) % 1024];
      spi_miso_i = b[7 - (d % 8)];
    end
  end

  // ---------------- read scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          rd_issue = 1'b0;

  always @(posedge clk) begin
    if (rd_issue) begin
      #1;
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rd_monitor: got %h with no expected entry", rd_data_o);
      end else begin
        chk(name_q.pop_front(), rd_data_o, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (load_done_o === 1'b1 && load_err_o === 1'b1) begin
      errs++;
      $display("FAIL done_err_exclusive: got done=1 err=1 expected at most one");
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; presents the address for the next rising edge.
  task automatic issue_rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    rd_addr_i = a;
    rd_issue  = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic rd_stop();
    rd_issue = 1'b0;
  endtask

  task automatic rand_reads(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(W, 255);
      else                           a = $urandom_range(0, W - 1);
      issue_rd(8'(a), model_rd(a), "rd_rand");
    end
    rd_stop();
  endtask

  task automatic wait_done(input int t0, input bit exp_err, input string nm);
    int lat;
    while (!(load_done_o === 1'b1 || load_err_o === 1'b1) &&
           (cyc_cnt - t0) < LOAD_CYC + 50) begin
      @(posedge clk);
      #1;
    end
    lat = cyc_cnt - t0;
    chk_win({nm, "_latency"}, lat, LOAD_CYC);
    chk({nm, "_done"}, 32'(load_done_o), 32'(!exp_err));
    chk({nm, "_err"},  32'(load_err_o),  32'(exp_err));
    @(negedge clk);
    model_done = !exp_err && (model_word(0) == MAGIC);
  endtask

  task automatic do_reload(input string nm, output int t0);
    @(negedge clk);
    reload_i = 1'b1;
    t0 = cyc_cnt;
    @(posedge clk);
    #1;
    reload_i = 1'b0;
    model_done = 1'b0;
    chk({nm, "_done_drop"}, 32'(load_done_o), 32'h0);
    chk({nm, "_err_drop"},  32'(load_err_o),  32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int guard;

    // Nominal load with a known word 1.
    fill_random(1'b1);
    set_word(1, 32'h0000_00A5);
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n_o), 32'h1);
    chk("rst_sck",  32'(spi_sck_o),  32'h0);
    chk("rst_mosi", 32'(spi_mosi_o), 32'h0);
    chk("rst_rd",   rd_data_o,       32'h0);
    chk("rst_done", 32'(load_done_o), 32'h0);
    chk("rst_err",  32'(load_err_o),  32'h0);

    @(negedge clk);
    rst_i = 1'b0;
    t0 = cyc_cnt;
    issue_rd(8'd0, 32'h0, "rd_before_done");
    rd_stop();
    wait_done(t0, 1'b0, "nominal");
    issue_rd(8'd1,   32'h0000_00A5, "rd_word1");
    issue_rd(8'd0,   32'h4D58_4944, "rd_magic_byte_order");
    issue_rd(8'(W),  32'h0,         "rd_out_of_range");
    issue_rd(8'd255, 32'h0,         "rd_addr_255");
    rd_stop();
    rand_reads(30);

    // Reset in the middle of the data phase, then a fresh load.
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    fill_random(1'b1);
    model_done = 1'b0;
    rst_i = 1'b0;
    guard = 0;
    while (fl_bits < 100 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_bit100", 32'(fl_bits >= 100), 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs_n", 32'(spi_cs_n_o), 32'h1);
    chk("midrst_sck",  32'(spi_sck_o),  32'h0);
    chk("midrst_mosi", 32'(spi_mosi_o), 32'h0);
    chk("midrst_rd",   rd_data_o,       32'h0);
    chk("midrst_done", 32'(load_done_o), 32'h0);
    chk("midrst_err",  32'(load_err_o),  32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    t0 = cyc_cnt;
    wait_done(t0, 1'b0, "after_midrst");
    rand_reads(30);

    // Reload with a changed word 2.
    set_word(2, 32'h1234_5678);
    do_reload("reload1", t0);
    @(negedge clk);
    wait_done(t0, 1'b0, "reload1");
    issue_rd(8'd2, 32'h1234_5678, "rd_word2_reloaded");
    rd_stop();
    rand_reads(20);

    // Reload pulse during DATA must not restart the load.
    fill_random(1'b1);
    do_reload("reload2", t0);
    repeat (1600) @(negedge clk);
    reload_i = 1'b1;
    @(negedge clk);
    reload_i = 1'b0;
    wait_done(t0, 1'b0, "reload_in_data");
    rand_reads(20);

    // Bad magic word.
    fill_random(1'b0);
    set_word(0, 32'hFFFF_FFFF);
    do_reload("reload_bad", t0);
    @(negedge clk);
    wait_done(t0, 1'b1, "bad_magic");
    for (int a = 0; a < 256; a++) issue_rd(8'(a), 32'h0, "rd_bad_magic");
    rd_stop();

    // Recovery from ERR with a valid image.
    fill_random(1'b1);
    do_reload("reload_fix", t0);
    @(negedge clk);
    wait_done(t0, 1'b0, "recover");
    rand_reads(30);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected sequence end");
    $fatal(1, "watchdog");
  end

endmodule
